// File: rtl/bss_button_pkg.sv
// Shared definitions for the button event path: FSM state encoding, input
// polarity names and a small elaboration-time helper.
package bss_button_pkg;

  localparam logic [1:0] ST_RELEASED  = 2'd0;
  localparam logic [1:0] ST_HELD      = 2'd1;
  localparam logic [1:0] ST_LONG_HELD = 2'd2;

  localparam string POL_LOW  = "LOW";
  localparam string POL_HIGH = "HIGH";

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_event_chan.sv
// One button channel: synchroniser, debounce counter and press/hold FSM.
// Auto-repeat while long-held is built only with BUTTON_EVENT_AUTOREPEAT_EN.
module button_event_chan
  import bss_button_pkg::*;
#(
  parameter string POLARITY      = POL_LOW,
  parameter int    TIMEOUT       = 50000,
  parameter int    TIMEOUT_WIDTH = 16,
  parameter int    LONG_PRESS    = 25000000,
  parameter int    LONG_WIDTH    = 25,
  parameter int    REPEAT        = 5000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic data_in,
  output logic data_out,
  output logic press,
  output logic release_pulse,
  output logic long_press,
  output logic held_long
);

  // Synchroniser resets to the idle pin level so a key held across reset
  // still has to travel the full synchroniser + debounce path.
  localparam logic IDLE_LEVEL = (POLARITY == POL_HIGH) ? 1'b0 : 1'b1;

  localparam logic [TIMEOUT_WIDTH-1:0] CNT_LAST  = TIMEOUT_WIDTH'(TIMEOUT - 1);
  localparam logic [LONG_WIDTH-1:0]    HOLD_LONG = LONG_WIDTH'(LONG_PRESS - 1);
  localparam logic [LONG_WIDTH-1:0]    HOLD_MAX  = '1;
`ifdef BUTTON_EVENT_AUTOREPEAT_EN
  localparam logic [LONG_WIDTH-1:0]    HOLD_REP  = LONG_WIDTH'(REPEAT - 1);
`endif

  if ((POLARITY != POL_LOW) && (POLARITY != POL_HIGH)) begin : g_bad_polarity
    $error("button_event_chan: POLARITY must be LOW or HIGH");
  end
  if ((longint'(1) << TIMEOUT_WIDTH) <= longint'(TIMEOUT)) begin : g_bad_timeout_width
    $error("button_event_chan: TIMEOUT_WIDTH too small for TIMEOUT");
  end
  if ((longint'(1) << LONG_WIDTH) <= longint'(max_int(LONG_PRESS, REPEAT))) begin : g_bad_long_width
    $error("button_event_chan: LONG_WIDTH too small for LONG_PRESS/REPEAT");
  end

  logic [1:0]               sync;
  logic                     raw_n;
  logic                     change;
  logic                     accept;
  logic [TIMEOUT_WIDTH-1:0] cnt;
  logic [1:0]               state;
  logic [LONG_WIDTH-1:0]    hold;

  assign raw_n  = sync[1] ^ IDLE_LEVEL;
  assign change = raw_n ^ data_out;
  assign accept = change && (cnt == CNT_LAST);

  // NOTE: all state here is sequential and uses <= so every read in this
  // block sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync          <= {2{IDLE_LEVEL}};
      cnt           <= '0;
      data_out      <= 1'b0;
      state         <= ST_RELEASED;
      hold          <= '0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      held_long     <= 1'b0;
    end else begin
      sync <= {sync[0], data_in};

      if (!change || accept) cnt <= '0;
      else                   cnt <= cnt + 1'b1;

      if (accept) data_out <= ~data_out;

      // Event pulses default low and are raised only on the cycle they fire.
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;

      case (state)
        ST_RELEASED: begin
          if (accept) begin
            state <= ST_HELD;
            press <= 1'b1;
            hold  <= '0;
          end
        end
        ST_HELD: begin
          if (accept) begin
            state         <= ST_RELEASED;
            release_pulse <= 1'b1;
            hold          <= '0;
          end else if (hold == HOLD_LONG) begin
            state      <= ST_LONG_HELD;
            long_press <= 1'b1;
            held_long  <= 1'b1;
`ifdef BUTTON_EVENT_AUTOREPEAT_EN
            hold       <= '0;
`endif
          end else if (hold != HOLD_MAX) begin
            hold <= hold + 1'b1;
          end
        end
        ST_LONG_HELD: begin
          if (accept) begin
            state         <= ST_RELEASED;
            release_pulse <= 1'b1;
            held_long     <= 1'b0;
            hold          <= '0;
          end
`ifdef BUTTON_EVENT_AUTOREPEAT_EN
          else if (hold == HOLD_REP) begin
            press <= 1'b1;
            hold  <= '0;
          end else begin
            hold <= hold + 1'b1;
          end
`endif
        end
        default: begin
          state     <= ST_RELEASED;
          held_long <= 1'b0;
          hold      <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_event_ctrl.sv
// N-channel button event controller: debounced levels plus press, release and
// long-press pulses. Define BUTTON_EVENT_AUTOREPEAT_EN for auto-repeat presses.
module button_event_ctrl
  import bss_button_pkg::*;
#(
  parameter int    WIDTH         = 2,
  parameter string POLARITY      = POL_LOW,
  parameter int    TIMEOUT       = 50000,
  parameter int    TIMEOUT_WIDTH = 16,
  parameter int    LONG_PRESS    = 25000000,
  parameter int    LONG_WIDTH    = 25,
  parameter int    REPEAT        = 5000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] press,
  output logic [WIDTH-1:0] release_pulse,
  output logic [WIDTH-1:0] long_press,
  output logic [WIDTH-1:0] held_long
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    button_event_chan #(
      .POLARITY      (POLARITY),
      .TIMEOUT       (TIMEOUT),
      .TIMEOUT_WIDTH (TIMEOUT_WIDTH),
      .LONG_PRESS    (LONG_PRESS),
      .LONG_WIDTH    (LONG_WIDTH),
      .REPEAT        (REPEAT)
    ) u_chan (
      .clk           (clk),
      .reset_n       (reset_n),
      .data_in       (data_in[i]),
      .data_out      (data_out[i]),
      .press         (press[i]),
      .release_pulse (release_pulse[i]),
      .long_press    (long_press[i]),
      .held_long     (held_long[i])
    );
  end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed bench for button_event_ctrl with short timing parameters; the
// repeat-count expectation follows BUTTON_EVENT_AUTOREPEAT_EN.
module tb_button_event_ctrl;

  localparam int TIMEOUT    = 4;
  localparam int LONG_PRESS = 20;
  localparam int REPEAT     = 8;

`ifdef BUTTON_EVENT_AUTOREPEAT_EN
  localparam int EXP_REPEATS = 7;
`else
  localparam int EXP_REPEATS = 0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] data_in;
  logic [1:0] data_out;
  logic [1:0] press;
  logic [1:0] release_pulse;
  logic [1:0] long_press;
  logic [1:0] held_long;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [1:0] act;

  button_event_ctrl #(
    .WIDTH         (2),
    .POLARITY      ("LOW"),
    .TIMEOUT       (TIMEOUT),
    .TIMEOUT_WIDTH (4),
    .LONG_PRESS    (LONG_PRESS),
    .LONG_WIDTH    (6),
    .REPEAT        (REPEAT)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .data_in       (data_in),
    .data_out      (data_out),
    .press         (press),
    .release_pulse (release_pulse),
    .long_press    (long_press),
    .held_long     (held_long)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic watch(input int n);
    repeat (n) begin
      tick(1);
      act = act | data_out | press | release_pulse | long_press;
    end
  endtask

  // Cycles until any long_press bit rises, bounded at 100.
  task automatic wait_long(output int n);
    n = 0;
    do begin
      tick(1);
      n++;
    end while (long_press == 2'b00 && n < 100);
  endtask

  int n_wait;
  int reps;
  int lps;

  initial begin
    reset_n = 1'b0;
    data_in = 2'b11;
    tick(3);
    check("rst_data_out",   data_out,      0);
    check("rst_press",      press,         0);
    check("rst_release",    release_pulse, 0);
    check("rst_long_press", long_press,    0);
    check("rst_held_long",  held_long,     0);
    reset_n = 1'b1;
    tick(8);
    check("idle_data_out", data_out, 0);

    // Clean press on channel 0: accepted 2 + TIMEOUT edges later.
    data_in[0] = 1'b0;
    tick(5);
    check("press_early_data_out", data_out, 0);
    check("press_early_press",    press,    0);
    tick(1);
    check("press_data_out",   data_out,      2'b01);
    check("press_pulse",      press,         2'b01);
    check("press_release",    release_pulse, 0);
    check("press_long_press", long_press,    0);

    wait_long(n_wait);
    check("long_latency",   n_wait,     LONG_PRESS);
    check("long_pulse",     long_press, 2'b01);
    check("long_held_long", held_long,  2'b01);

    reps = 0;
    lps  = 0;
    for (int k = 0; k < 60; k++) begin
      tick(1);
      if (press[0])      reps++;
      if (long_press[0]) lps++;
    end
    check("repeat_count",       reps,      EXP_REPEATS);
    check("long_once",          lps,       0);
    check("repeat_held_long",   held_long, 2'b01);
    check("repeat_data_out",    data_out,  2'b01);

    // Release from LONG_HELD.
    data_in[0] = 1'b1;
    tick(5);
    check("rel_early", release_pulse, 0);
    tick(1);
    check("rel_pulse",     release_pulse, 2'b01);
    check("rel_data_out",  data_out,      0);
    check("rel_held_long", held_long,     0);
    check("rel_press",     press,         0);
    tick(1);
    check("rel_single", release_pulse, 0);
    tick(4);

    // Single 3-cycle glitch, then repeated 3-low/1-high bursts.
    act = 2'b00;
    data_in[0] = 1'b0;
    watch(3);
    data_in[0] = 1'b1;
    watch(10);
    check("glitch_single", act, 0);
    act = 2'b00;
    for (int b = 0; b < 4; b++) begin
      data_in[0] = 1'b0;
      watch(3);
      data_in[0] = 1'b1;
      watch(1);
    end
    watch(10);
    check("glitch_burst", act, 0);

    // Reset while HELD, key kept down across reset.
    data_in[0] = 1'b0;
    tick(6);
    check("rh_press", press, 2'b01);
    tick(3);
    reset_n = 1'b0;
    #1;
    check("rh_data_out",  data_out,      0);
    check("rh_release",   release_pulse, 0);
    check("rh_held_long", held_long,     0);
    tick(2);
    check("rh_release_in_rst", release_pulse, 0);
    reset_n = 1'b1;
    tick(5);
    check("rh_press_early", press, 0);
    tick(1);
    check("rh_press_after", press,    2'b01);
    check("rh_data_after",  data_out, 2'b01);
    data_in[0] = 1'b1;
    tick(10);
    check("rh_released", data_out, 0);

    // Both channels pressed together, then ch1 released during ch0 LONG_HELD.
    data_in = 2'b00;
    tick(6);
    check("both_press",    press,    2'b11);
    check("both_data_out", data_out, 2'b11);
    wait_long(n_wait);
    check("both_long_latency", n_wait,     LONG_PRESS);
    check("both_long",         long_press, 2'b11);
    tick(3);
    data_in[1] = 1'b1;
    tick(6);
    check("ch1_release",     release_pulse, 2'b10);
    check("ch1_data_out",    data_out,      2'b01);
    check("ch1_held_long",   held_long,     2'b01);
    check("ch1_long_quiet",  long_press,    0);
    data_in[0] = 1'b1;
    tick(6);
    check("ch0_release",  release_pulse, 2'b01);
    check("end_data_out", data_out,      0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/button_event_ctrl.md
Name: button_event_ctrl

Overview:
- Parametrised successor to the board-level key debounce path: N independent channels, each synchronised, debounced and decoded into press, release and long-press event pulses.
- Sits between the raw KEY/SW pins and the HPS-facing PIO/STM event inputs.
- Runs in the 50 MHz FPGA fabric clock domain.
- Reset is driven by the HPS h2f reset.

Parameters:
- WIDTH, 2: number of input channels.
- POLARITY, "LOW": active level of raw inputs, "LOW" or "HIGH". Outputs are always active-high.
- TIMEOUT, 50000: consecutive stable cycles required to accept a level change (1 ms at 50 MHz).
- TIMEOUT_WIDTH, 16: debounce counter width; must satisfy 2^TIMEOUT_WIDTH > TIMEOUT.
- LONG_PRESS, 25000000: cycles in the held state before long_press fires (0.5 s).
- LONG_WIDTH, 25: hold counter width; must satisfy 2^LONG_WIDTH > max(LONG_PRESS, REPEAT).
- REPEAT, 5000000: auto-repeat period in cycles (used only with AUTOREPEAT_EN).

Ports:
- clk, input, 1: fabric clock, all logic on rising edge.
- reset_n, input, 1: asynchronous active-low reset; deassertion assumed synchronous to clk.
- data_in, input, WIDTH: raw asynchronous button/switch levels.
- data_out, output, WIDTH: debounced level, 1 = pressed.
- press, output, WIDTH: 1-cycle pulse on accepted press (and on auto-repeat).
- release, output, WIDTH: 1-cycle pulse on accepted release.
- long_press, output, WIDTH: 1-cycle pulse when hold reaches LONG_PRESS.
- held_long, output, WIDTH: level, 1 while the channel is in LONG_HELD.

Behaviour:
- Reset: all outputs are 0; all channels enter RELEASED; all counters are 0. No release pulse is generated by reset.
- Per channel:
  - 2-flop synchroniser, then polarity normalisation into raw_n (1 = pressed).
- Debounce:
  - cnt clears whenever raw_n equals data_out.
  - cnt increments each cycle raw_n differs from data_out.
  - When cnt == TIMEOUT-1 and raw_n still differs, data_out toggles on that edge and cnt clears.
  - Accepted-change latency: exactly 2 + TIMEOUT cycles after a clean input edge.
  - Glitches shorter than TIMEOUT cycles produce no output activity.
- FSM states: RELEASED, HELD, LONG_HELD.
  - RELEASED -> HELD on accepted press. press=1 that cycle; hold counter clears.
  - HELD: hold counter increments each cycle. On hold == LONG_PRESS-1, go to LONG_HELD with long_press=1 and held_long=1 from the next cycle.
  - HELD or LONG_HELD -> RELEASED on accepted release. release=1 that cycle; held_long clears.
  - A release accepted on the same cycle hold reaches LONG_PRESS-1 takes priority: release=1, long_press=0.
  - Hold counter saturates at its maximum (no wrap).
- Event pulses are registered and aligned with the data_out transition cycle.
- Channels are fully independent; simultaneous events on several channels all appear in the same cycle.
- Reset mid-debounce or mid-hold discards all progress. A key held across reset deassertion yields press 2 + TIMEOUT cycles later.

Optional Feature:
- Macro: BUTTON_EVENT_AUTOREPEAT_EN.
- Defined:
  - In LONG_HELD, the hold counter restarts at 0 on entry.
  - press pulses each time the counter reaches REPEAT-1; the counter then clears.
  - Repeat stops on release, and the final repeat pulse is suppressed if release is accepted that cycle.
- Undefined:
  - LONG_HELD emits no press pulses.
  - The REPEAT parameter is ignored and its counter logic is absent.

Decomposition:
- Shared package/include bss_button_pkg:
  - FSM state encoding (RELEASED=2'd0, HELD=2'd1, LONG_HELD=2'd2).
  - POLARITY string constants.
- Sub-module button_event_chan: one channel (synchroniser, debounce counter, FSM, hold counter). Instantiated WIDTH times by a generate loop in button_event_ctrl.

Test Plan:
- Test parameters: TIMEOUT=4, LONG_PRESS=20, REPEAT=8, POLARITY="LOW", WIDTH=2.
- Clean press: data_in[0] 1->0 at cycle 0, held -> data_out[0] rises at cycle 6 with press[0]=1 for exactly one cycle; release/long_press stay 0.
- Glitch rejection: data_in[0] low for 3 cycles then high -> data_out, press and release stay 0. Repeated 3-cycle bursts with 1-cycle gaps -> still no activity.
- Long press and release: hold low -> long_press[0] pulses 20 cycles after press[0] and held_long[0]=1. Release -> release[0] pulses 6 cycles after data_in rises; held_long[0]=0 the next cycle.
- Auto-repeat (macro defined): hold 60 cycles past long_press -> press[0] pulses every 8 cycles (7 pulses). Macro undefined -> 0 pulses.
- Reset mid-hold: assert reset_n=0 in HELD -> all outputs 0 immediately, no release pulse. Deassert with key still low -> press[0] 6 cycles later.
- Channel independence: press ch0 and ch1 on the same cycle -> both press bits pulse on the same cycle. Release ch1 during ch0 LONG_HELD -> ch0 unaffected.
